// File: rtl/i8085_bus_responder_pkg.sv
// Shared widths, idle bus data and FSM state codes for the i8085 bus responder.
package i8085_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] IDLE_DATA = 8'hFF;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_RD_REQ   = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_DRIVE = 3'd4;
    localparam logic [2:0] ST_WR_REQ   = 3'd5;
    localparam logic [2:0] ST_WR_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

endpackage

// File: rtl/i8085_bus_responder_if.sv
// CPU multiplexed bus pins plus the backend valid/ready request channel of the bus responder.
interface i8085_bus_responder_if;
    import i8085_bus_pkg::*;

    logic                       ale;
    logic [DATA_W-1:0]          ad_in;
    logic [ADDR_W-DATA_W-1:0]   a_hi;
    logic                       io_m_n;
    logic                       rd_n;
    logic                       wr_n;
    logic [DATA_W-1:0]          ad_out;
    logic                       ad_oe;
    logic                       ready;
    logic                       proto_err;
    logic                       bus_err;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic                       req_io;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;

    modport slave (
        input  ale, ad_in, a_hi, io_m_n, rd_n, wr_n, req_ready, rsp_valid, rsp_rdata,
        output ad_out, ad_oe, ready, proto_err, bus_err,
               req_valid, req_write, req_io, req_addr, req_wdata
    );

    modport master (
        output ale, ad_in, a_hi, io_m_n, rd_n, wr_n, req_ready, rsp_valid, rsp_rdata,
        input  ad_out, ad_oe, ready, proto_err, bus_err,
               req_valid, req_write, req_io, req_addr, req_wdata
    );

endinterface

// File: rtl/i8085_bus_responder_bus_wait_timer.sv
// Min-wait down-counter for READY stretching; with BUS_TIMEOUT_EN also an access-timeout down-counter.
module bus_wait_timer #(
    parameter int MIN_WAIT       = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic minElapsed_o,
    output logic timeout_o
);

    // Min wait is capped below the timeout so an expired access can always complete on the expiry edge.
    localparam int MW_CAP = (MIN_WAIT < TIMEOUT_CYCLES) ? MIN_WAIT : TIMEOUT_CYCLES - 1;
    localparam int MW_EFF = (MW_CAP > 15) ? 15 : ((MW_CAP < 0) ? 0 : MW_CAP);

    logic [3:0] waitCnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q <= 4'd0;
        end else if (load_i) begin
            waitCnt_q <= 4'(MW_EFF);
        end else if (waitCnt_q != 4'd0) begin
            waitCnt_q <= waitCnt_q - 4'd1;
        end
    end

    // Decision edges see last cycle's count, so "elapsed" means one remaining, not zero.
    assign minElapsed_o = (waitCnt_q <= 4'd1);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] toCnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt_q <= '0;
        end else if (load_i) begin
            toCnt_q <= TW'(TIMEOUT_CYCLES);
        end else if (toCnt_q != '0) begin
            toCnt_q <= toCnt_q - TW'(1);
        end
    end

    assign timeout_o = (toCnt_q == TW'(1));
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/i8085_bus_responder.sv
// Slave side of the 8085 multiplexed bus: turns bus cycles into backend requests and stretches READY.
// Optional access timeout is enabled with the BUS_TIMEOUT_EN macro.
module i8085_bus_responder
    import i8085_bus_pkg::*;
#(
    parameter int MIN_WAIT       = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    i8085_bus_responder_if.slave  bus
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   adOut_q, adOut_d;
    logic                adOe_q, adOe_d;
    logic                ready_q, ready_d;
    logic                protoErr_q, protoErr_d;
    logic                busErr_q, busErr_d;
    logic                reqValid_q, reqValid_d;
    logic                reqWrite_q, reqWrite_d;
    logic                reqIo_q, reqIo_d;
    logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
    logic [DATA_W-1:0]   reqWdata_q, reqWdata_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic timerLoad;
    logic minElapsed;
    logic timeout;
    logic isRead;
    logic inReq;
    logic released;
    logic abortNow;
    logic accepted;
    logic rspNow;
    logic complete;

    bus_wait_timer #(
        .MIN_WAIT       (MIN_WAIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) waitTimer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (timerLoad),
        .minElapsed_o (minElapsed),
        .timeout_o    (timeout)
    );

    assign isRead   = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
    assign inReq    = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign released = isRead ? bus.rd_n : bus.wr_n;
    assign abortNow = abort_q | released;
    assign accepted = reqValid_q & bus.req_ready;
    // A response only counts in a request state when it coincides with acceptance.
    assign rspNow   = bus.rsp_valid & (~inReq | accepted);
    assign complete = done_q | rspNow;

    always_comb begin
        state_d    = state_q;
        adOut_d    = adOut_q;
        adOe_d     = adOe_q;
        ready_d    = ready_q;
        protoErr_d = 1'b0;
        busErr_d   = 1'b0;
        reqValid_d = reqValid_q;
        reqWrite_d = reqWrite_q;
        reqIo_d    = reqIo_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        done_d     = done_q;
        abort_d    = abort_q;
        timerLoad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ale) begin
                    reqAddr_d = {bus.a_hi, bus.ad_in};
                    reqIo_d   = bus.io_m_n;
                    state_d   = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (!bus.rd_n && !bus.wr_n) begin
                    protoErr_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (!bus.rd_n || !bus.wr_n) begin
                    reqWrite_d = ~bus.wr_n;
                    if (!bus.wr_n) begin
                        reqWdata_d = bus.ad_in;
                    end
                    reqValid_d = 1'b1;
                    ready_d    = 1'b0;
                    done_d     = 1'b0;
                    abort_d    = 1'b0;
                    timerLoad  = 1'b1;
                    state_d    = bus.wr_n ? ST_RD_REQ : ST_WR_REQ;
                end else if (bus.ale) begin
                    reqAddr_d = {bus.a_hi, bus.ad_in};
                    reqIo_d   = bus.io_m_n;
                end
            end

            ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT: begin
                if (released) begin
                    abort_d = 1'b1;
                end
                if (inReq && accepted) begin
                    reqValid_d = 1'b0;
                    state_d    = isRead ? ST_RD_WAIT : ST_WR_WAIT;
                end
                if (rspNow) begin
                    done_d = 1'b1;
                    if (isRead && !abortNow) begin
                        adOut_d = bus.rsp_rdata;
                    end
                end

                // An abandoned strobe still lets the backend finish, then flags the violation.
                if (complete && abortNow) begin
                    reqValid_d = 1'b0;
                    ready_d    = 1'b1;
                    protoErr_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (complete && !inReq && minElapsed) begin
                    ready_d = 1'b1;
                    if (isRead) begin
                        adOe_d  = 1'b1;
                        state_d = ST_RD_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (timeout && !complete) begin
                    reqValid_d = 1'b0;
                    busErr_d   = 1'b1;
                    ready_d    = 1'b1;
                    if (abortNow) begin
                        protoErr_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (isRead) begin
                        adOut_d = IDLE_DATA;
                        adOe_d  = 1'b1;
                        state_d = ST_RD_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RD_DRIVE: begin
                if (bus.rd_n) begin
                    adOe_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (bus.rd_n && bus.wr_n) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            adOut_q    <= '0;
            adOe_q     <= 1'b0;
            ready_q    <= 1'b1;
            protoErr_q <= 1'b0;
            busErr_q   <= 1'b0;
            reqValid_q <= 1'b0;
            reqWrite_q <= 1'b0;
            reqIo_q    <= 1'b0;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            adOut_q    <= adOut_d;
            adOe_q     <= adOe_d;
            ready_q    <= ready_d;
            protoErr_q <= protoErr_d;
            busErr_q   <= busErr_d;
            reqValid_q <= reqValid_d;
            reqWrite_q <= reqWrite_d;
            reqIo_q    <= reqIo_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.ad_out    = adOut_q;
    assign bus.ad_oe     = adOe_q;
    assign bus.ready     = ready_q;
    assign bus.proto_err = protoErr_q;
    assign bus.bus_err   = busErr_q;
    assign bus.req_valid = reqValid_q;
    assign bus.req_write = reqWrite_q;
    assign bus.req_io    = reqIo_q;
    assign bus.req_addr  = reqAddr_q;
    assign bus.req_wdata = reqWdata_q;

endmodule
